// File: rtl/mod_counter_ud.sv
// Parametrised modulo-N up/down counter updating on the falling edge of ck.
// Optional wrap event counter port enabled by defining MOD_COUNTER_WRAPCNT_EN.
module mod_counter_ud #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 21
) (
    input  logic             ck,
    input  logic             rs,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             os,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
`ifdef MOD_COUNTER_WRAPCNT_EN
    output logic [7:0]       wrap_cnt,
`endif
    output logic             done
);

    localparam int               MAX_INT = MODULUS - 1;
    localparam logic [WIDTH:0]   MOD_W   = MODULUS[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_INT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             at_terminal;
    logic             q_in_range;
    logic             d_in_range;

    assign at_terminal = up_dn ? (q_q == MAX_VAL) : (q_q == '0);
    // The extra top bit lets MODULUS = 2**WIDTH compare without overflow.
    assign q_in_range  = ({1'b0, q_q} < MOD_W);
    assign d_in_range  = ({1'b0, d} < MOD_W);

    always_comb begin
        q_d    = q_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d    = '0;
            done_d = 1'b0;
        end else if (ld) begin
            q_d    = d_in_range ? d : '0;
            done_d = 1'b0;
        end else if (en) begin
            if (!q_in_range) begin
                q_d = '0;
            end else if (os) begin
                // One-shot freezes once terminal is reached, even if direction later flips.
                if (done_q) begin
                    q_d = q_q;
                end else if (at_terminal) begin
                    done_d = 1'b1;
                end else begin
                    q_d = up_dn ? (q_q + ONE) : (q_q - ONE);
                end
            end else if (up_dn) begin
                if (q_q == MAX_VAL) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = MAX_VAL;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(negedge ck or negedge rs) begin
        if (!rs) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign q    = q_q;
    assign tc   = at_terminal;
    assign wrap = wrap_q;
    assign done = done_q;

`ifdef MOD_COUNTER_WRAPCNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // Saturates at 255; load deliberately leaves the count intact.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            wrap_cnt_d = '0;
        end else if (wrap_d && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(negedge ck or negedge rs) begin
        if (!rs) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_mod_counter_ud.sv
// Directed self-checking bench for mod_counter_ud (WIDTH=5, MODULUS=21).
// Exercises the wrap_cnt port only when MOD_COUNTER_WRAPCNT_EN is defined.
module tb_mod_counter_ud;

    logic       ck = 1'b1;
    logic       rs = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic [4:0] d = '0;
    logic       os = 1'b0;
    logic [4:0] q;
    logic       tc;
    logic       wrap;
    logic       done;
`ifdef MOD_COUNTER_WRAPCNT_EN
    logic [7:0] wrap_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mod_counter_ud #(.WIDTH(5), .MODULUS(21)) dut (
        .ck(ck), .rs(rs), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld),
        .d(d), .os(os), .q(q), .tc(tc), .wrap(wrap),
`ifdef MOD_COUNTER_WRAPCNT_EN
        .wrap_cnt(wrap_cnt),
`endif
        .done(done)
    );

    always #10 ck = ~ck;

    // Advance one falling edge, then settle before sampling.
    task automatic tick();
        @(negedge ck);
        #1;
    endtask

    task automatic test_reset();
        rs = 1'b0;
        #100;
        checks++;
        if (q !== 5'd0 || wrap !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state q=%0d wrap=%b done=%b expected q=0 wrap=0 done=0", q, wrap, done);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tc tc=%b expected 0", tc);
        end
        rs = 1'b1;
        tick();
    endtask

    task automatic test_count_up();
        logic [4:0] exp_q;
        en = 1'b1; up_dn = 1'b1; os = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            exp_q = 5'(i % 21);
            checks++;
            if (q !== exp_q || wrap !== (i == 21) || tc !== (exp_q == 5'd20)) begin
                errors++;
                $display("[TB] FAIL up_edge%0d q=%0d wrap=%b tc=%b expected q=%0d wrap=%b tc=%b",
                         i, q, wrap, tc, exp_q, (i == 21), (exp_q == 5'd20));
            end
        end
    endtask

    task automatic test_count_down();
        logic [4:0] exp_q;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        up_dn = 1'b0;
        #1;
        checks++;
        if (q !== 5'd0 || tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL down_tc_at0 q=%0d tc=%b expected q=0 tc=1", q, tc);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_q = 5'(21 - i);
            checks++;
            if (q !== exp_q || wrap !== (i == 1)) begin
                errors++;
                $display("[TB] FAIL down_edge%0d q=%0d wrap=%b expected q=%0d wrap=%b",
                         i, q, wrap, exp_q, (i == 1));
            end
        end
        up_dn = 1'b1;
        tick();
        checks++;
        if (q !== 5'd6 || wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dir_flip q=%0d wrap=%b expected q=6 wrap=0", q, wrap);
        end
    endtask

    task automatic test_load();
        en = 1'b0; ld = 1'b1;
        d = 5'd17;
        tick();
        checks++;
        if (q !== 5'd17) begin
            errors++;
            $display("[TB] FAIL ld_17 q=%0d expected 17", q);
        end
        d = 5'd25;
        tick();
        checks++;
        if (q !== 5'd0) begin
            errors++;
            $display("[TB] FAIL ld_25_guard q=%0d expected 0", q);
        end
        d = 5'd21;
        tick();
        checks++;
        if (q !== 5'd0) begin
            errors++;
            $display("[TB] FAIL ld_21_guard q=%0d expected 0", q);
        end
        d = 5'd20;
        tick();
        checks++;
        if (q !== 5'd20) begin
            errors++;
            $display("[TB] FAIL ld_20_max q=%0d expected 20", q);
        end
        d = 5'd3; en = 1'b1;
        tick();
        checks++;
        if (q !== 5'd3 || wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ld_with_en q=%0d wrap=%b expected q=3 wrap=0", q, wrap);
        end
        ld = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (q !== 5'd3) begin
            errors++;
            $display("[TB] FAIL idle_hold q=%0d expected 3", q);
        end
    endtask

    task automatic test_one_shot();
        logic [4:0] exp_q [5] = '{5'd19, 5'd20, 5'd20, 5'd20, 5'd20};
        logic       exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        os = 1'b1; up_dn = 1'b1; en = 1'b0; ld = 1'b1; d = 5'd18;
        tick();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) up_dn = 1'b0;
            tick();
            checks++;
            if (q !== exp_q[i] || done !== exp_d[i] || wrap !== 1'b0) begin
                errors++;
                $display("[TB] FAIL oneshot_edge%0d q=%0d done=%b wrap=%b expected q=%0d done=%b wrap=0",
                         i, q, done, wrap, exp_q[i], exp_d[i]);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (q !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oneshot_clr q=%0d done=%b expected q=0 done=0", q, done);
        end
        os = 1'b0; up_dn = 1'b1;
    endtask

    task automatic test_async_reset();
        en = 1'b1; up_dn = 1'b1; os = 1'b0;
        repeat (9) tick();
        checks++;
        if (q !== 5'd9) begin
            errors++;
            $display("[TB] FAIL pre_reset q=%0d expected 9", q);
        end
        #5;
        rs = 1'b0;
        #1;
        checks++;
        if (q !== 5'd0 || done !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset q=%0d done=%b wrap=%b expected q=0 done=0 wrap=0", q, done, wrap);
        end
        #2;
        rs = 1'b1;
        tick();
        checks++;
        if (q !== 5'd1) begin
            errors++;
            $display("[TB] FAIL post_reset_count q=%0d expected 1", q);
        end
    endtask

`ifdef MOD_COUNTER_WRAPCNT_EN
    task automatic test_wrap_cnt();
        en = 1'b1; up_dn = 1'b1; os = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (wrap_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrapcnt_clr0 wrap_cnt=%0d expected 0", wrap_cnt);
        end
        repeat (63) tick();
        checks++;
        if (wrap_cnt !== 8'd3 || q !== 5'd0) begin
            errors++;
            $display("[TB] FAIL wrapcnt_3 wrap_cnt=%0d q=%0d expected wrap_cnt=3 q=0", wrap_cnt, q);
        end
        ld = 1'b1; d = 5'd5;
        tick();
        ld = 1'b0;
        checks++;
        if (wrap_cnt !== 8'd3 || q !== 5'd5) begin
            errors++;
            $display("[TB] FAIL wrapcnt_ld_keep wrap_cnt=%0d q=%0d expected wrap_cnt=3 q=5", wrap_cnt, q);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (wrap_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrapcnt_clr wrap_cnt=%0d expected 0", wrap_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_one_shot();
        test_async_reset();
`ifdef MOD_COUNTER_WRAPCNT_EN
        test_wrap_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
